// File: rtl/prom_spi_responder.sv
// prom_spi_responder: SPI mode-0 serial EEPROM (25AA128-class)
// emulation on oversampled pins, with a host preload/readback port.
module prom_spi_responder #(
  parameter int unsigned ADDR_WIDTH   = 14,
  parameter int unsigned PAGE_BITS    = 6,
  parameter logic [15:0] WRITE_CYCLES = 16'd5000
) (
  input  logic                  sysclk,
  input  logic                  reset,
  input  logic                  prom_sclk,
  input  logic                  prom_mosi,
  input  logic                  prom_cs_n,
  output logic                  prom_miso,
  output logic                  prom_miso_oe,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  input  logic [7:0]            host_wdata,
  input  logic                  host_wen,
  output logic [7:0]            host_rdata,
  output logic                  busy,
  output logic                  wel
);

  localparam logic [7:0] OP_WRITE = 8'h02;
  localparam logic [7:0] OP_READ  = 8'h03;
  localparam logic [7:0] OP_WRDI  = 8'h04;
  localparam logic [7:0] OP_RDSR  = 8'h05;
  localparam logic [7:0] OP_WREN  = 8'h06;
  localparam logic [ADDR_WIDTH-1:0] A_ONE = 1;
  localparam logic [PAGE_BITS-1:0]  P_ONE = 1;

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR, RD_DATA, WR_DATA, STAT, IGNORE
  } state_t;

  state_t state_q, state_d;

  logic [2:0] sck_q;
  logic [2:0] cs_q;
  logic [1:0] mosi_q;

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sck_q  <= 3'b000;
      cs_q   <= 3'b111;
      mosi_q <= 2'b00;
    end else begin
      sck_q  <= {sck_q[1:0], prom_sclk};
      cs_q   <= {cs_q[1:0], prom_cs_n};
      mosi_q <= {mosi_q[0], prom_mosi};
    end
  end

  logic sck_rise, sck_fall, cs_rise, cs_fall, mosi_s;
  assign sck_rise = sck_q[1] & ~sck_q[2];
  assign sck_fall = ~sck_q[1] & sck_q[2];
  assign cs_rise  = cs_q[1] & ~cs_q[2];
  assign cs_fall  = ~cs_q[1] & cs_q[2];
  assign mosi_s   = mosi_q[1];

  logic [3:0]            bit_cnt;
  logic [6:0]            sh_in;
  logic [7:0]            sh_out;
  logic [ADDR_WIDTH-1:0] addr;
  logic                  is_wr;
  logic                  wr_any;
  logic                  wr_req;
  logic [7:0]            wr_byte;
  logic [1:0]            pf;
  logic [7:0]            rd_q;
  logic [15:0]           wcnt;

  logic [7:0] in_byte;
  logic [7:0] status;
  logic       byte_end;
  logic       addr_end;
  logic       host_we;

  assign in_byte  = {sh_in, mosi_s};
  assign status   = {6'b0, wel, busy};
  assign byte_end = sck_rise && (bit_cnt == 4'd7);
  assign addr_end = sck_rise && (bit_cnt == 4'd15);
  assign host_we  = host_wen && cs_q[1] && (state_q == IDLE);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (cs_fall) state_d = CMD;
      CMD: begin
        if (byte_end) begin
          state_d = IGNORE;
          if (in_byte == OP_RDSR)
            state_d = STAT;
          else if (!busy && in_byte == OP_READ)
            state_d = ADDR;
          else if (!busy && wel && in_byte == OP_WRITE)
            state_d = ADDR;
        end
      end
      ADDR: if (addr_end) state_d = is_wr ? WR_DATA : RD_DATA;
      default: ;
    endcase
    if (cs_rise) state_d = IDLE;
  end

  logic [7:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge sysclk) begin
    if (wr_req)       mem[addr] <= wr_byte;
    else if (host_we) mem[host_addr] <= host_wdata;
    rd_q <= mem[addr];
  end

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      bit_cnt      <= '0;
      sh_in        <= '0;
      sh_out       <= '0;
      addr         <= '0;
      is_wr        <= 1'b0;
      wr_any       <= 1'b0;
      wr_req       <= 1'b0;
      wr_byte      <= '0;
      pf           <= '0;
      wcnt         <= '0;
      busy         <= 1'b0;
      wel          <= 1'b0;
      prom_miso    <= 1'b0;
      prom_miso_oe <= 1'b0;
      host_rdata   <= '0;
    end else begin
      host_rdata   <= mem[host_addr];
      prom_miso_oe <= (state_d == RD_DATA) || (state_d == STAT);
      wr_req       <= 1'b0;
      if (pf != 2'd0) pf <= pf - 2'd1;
      // read data lands in rd_q two cycles after the address settles
      if (pf == 2'd1) sh_out <= rd_q;
      if (wr_req)
        addr[PAGE_BITS-1:0] <= addr[PAGE_BITS-1:0] + P_ONE;
      if (busy) begin
        wcnt <= wcnt - 16'd1;
        if (wcnt <= 16'd1) busy <= 1'b0;
      end
      if (cs_fall) bit_cnt <= '0;
      if (cs_rise) begin
        bit_cnt <= '0;
        wr_any  <= 1'b0;
        if (wr_any) begin
          wel  <= 1'b0;
          busy <= 1'b1;
          wcnt <= WRITE_CYCLES;
        end
      end else if (sck_rise) begin
        sh_in   <= {sh_in[5:0], mosi_s};
        bit_cnt <= bit_cnt + 4'd1;
        unique case (state_q)
          CMD: if (byte_end) begin
            bit_cnt <= '0;
            is_wr   <= (in_byte == OP_WRITE);
            if (in_byte == OP_RDSR) sh_out <= status;
            if (!busy && in_byte == OP_WREN) wel <= 1'b1;
            if (!busy && in_byte == OP_WRDI) wel <= 1'b0;
          end
          ADDR: begin
            addr <= {addr[ADDR_WIDTH-2:0], mosi_s};
            if (addr_end) begin
              bit_cnt <= '0;
              if (!is_wr) pf <= 2'd2;
            end
          end
          RD_DATA: if (byte_end) begin
            bit_cnt <= '0;
            addr    <= addr + A_ONE;
            pf      <= 2'd2;
          end
          WR_DATA: if (byte_end) begin
            bit_cnt <= '0;
            wr_req  <= 1'b1;
            wr_byte <= in_byte;
            wr_any  <= 1'b1;
          end
          STAT: if (byte_end) begin
            bit_cnt <= '0;
            sh_out  <= status;
          end
          default: ;
        endcase
      end else if (sck_fall &&
                   (state_q == RD_DATA || state_q == STAT)) begin
        prom_miso <= sh_out[7];
        sh_out    <= {sh_out[6:0], 1'b0};
      end
    end
  end

endmodule
